bcd_to_bin: RTL and testbench

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_to_bin.sv | 103 ++++++++++
 tb/tb_bcd_to_bin.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Five-digit BCD to 16-bit binary converter.
// Digits are folded in MSD-first, one per cycle, with saturation and invalid-digit flagging.
module bcd_to_bin (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  D0,
    input  logic [3:0]  D1,
    input  logic [3:0]  D2,
    input  logic [3:0]  D3,
    input  logic [3:0]  D4,
    output logic [15:0] num,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e      state;
    logic [3:0]  dig [5];
    logic [16:0] acc;
    logic [16:0] acc_next;
    logic [2:0]  idx;
    logic [3:0]  cur_digit;
    logic        bad_digit;

    always_comb begin
        case (idx)
            3'd0:    cur_digit = dig[0];
            3'd1:    cur_digit = dig[1];
            3'd2:    cur_digit = dig[2];
            3'd3:    cur_digit = dig[3];
            3'd4:    cur_digit = dig[4];
            default: cur_digit = 4'd0;
        endcase
        bad_digit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (dig[i] > 4'd9) bad_digit = 1'b1;
        end
    end

    // 17 bits holds 99999, so valid digits never wrap; invalid ones are discarded by err anyway.
    assign acc_next = (acc << 3) + (acc << 1) + {13'd0, cur_digit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            num   <= 16'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
            err   <= 1'b0;
            acc   <= 17'd0;
            idx   <= 3'd0;
            for (int i = 0; i < 5; i++) dig[i] <= 4'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        dig[0] <= D0;
                        dig[1] <= D1;
                        dig[2] <= D2;
                        dig[3] <= D3;
                        dig[4] <= D4;
                        acc    <= 17'd0;
                        ovf    <= 1'b0;
                        err    <= 1'b0;
                        idx    <= 3'd4;
                        busy   <= 1'b1;
                        state  <= StConv;
                    end
                end
                StConv: begin
                    acc <= acc_next;
                    if (idx == 3'd0) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (bad_digit) begin
                            num <= 16'h0000;
                            err <= 1'b1;
                        end else if (acc_next > 17'd65535) begin
                            num <= 16'hFFFF;
                            ovf <= 1'b1;
                        end else begin
                            num <= acc_next[15:0];
                        end
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed scenarios plus random digits
// checked against an arithmetic reference model.
module tb_bcd_to_bin;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  D0, D1, D2, D3, D4;
    logic [15:0] num;
    logic        busy, done, ovf, err;

    int  tests;
    int  fails;
    time last_done_t;
    time prev_done_t;

    bcd_to_bin dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .D0    (D0),
        .D1    (D1),
        .D2    (D2),
        .D3    (D3),
        .D4    (D4),
        .num   (num),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain decimal value, then the err/ovf/saturate rules.
    task automatic model(input int d4, input int d3, input int d2, input int d1, input int d0,
                         output logic [15:0] m_num, output logic m_ovf, output logic m_err);
        int value;
        value = d4 * 10000 + d3 * 1000 + d2 * 100 + d1 * 10 + d0;
        m_err = (d4 > 9) || (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9);
        m_ovf = 1'b0;
        if (m_err) m_num = 16'h0000;
        else if (value > 65535) begin
            m_num = 16'hFFFF;
            m_ovf = 1'b1;
        end else m_num = value[15:0];
    endtask

    // Called at a negedge; start is sampled at the next posedge. Returns at the
    // negedge after the block is back in IDLE, so a following call runs back-to-back.
    task automatic do_conv(input string tag, input int d4, input int d3, input int d2,
                           input int d1, input int d0, input bit hold);
        logic [15:0] m_num;
        logic        m_ovf, m_err;
        model(d4, d3, d2, d1, d0, m_num, m_ovf, m_err);
        D4 = 4'(d4); D3 = 4'(d3); D2 = 4'(d2); D1 = 4'(d1); D0 = 4'(d0);
        start = 1'b1;
        @(negedge clk);
        start = hold;
        chk({tag, ":flags_cleared"}, {30'd0, ovf, err}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk({tag, ":busy_conv"}, {30'd0, busy, done}, 32'd2);
            if (hold) begin
                D4 = 4'($urandom_range(0, 15)); D3 = 4'($urandom_range(0, 15));
                D2 = 4'($urandom_range(0, 15)); D1 = 4'($urandom_range(0, 15));
                D0 = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, ":done"}, {30'd0, busy, done}, 32'd1);
        chk({tag, ":num"}, {16'd0, num}, {16'd0, m_num});
        chk({tag, ":ovf_err"}, {30'd0, ovf, err}, {30'd0, m_ovf, m_err});
        prev_done_t = last_done_t;
        last_done_t = $time;
        @(negedge clk);
        chk({tag, ":idle_held"}, {12'd0, busy, done, ovf, err, num},
            {12'd0, 1'b0, 1'b0, m_ovf, m_err, m_num});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        last_done_t = 0;
        prev_done_t = 0;
        rst = 1'b1;
        start = 1'b0;
        {D4, D3, D2, D1, D0} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", {12'd0, busy, done, ovf, err, num}, 32'd0);
        rst = 1'b0;

        do_conv("d12345", 1, 2, 3, 4, 5, 1'b0);
        chk("latency_5", 32'(last_done_t - prev_done_t) > 0 ? 32'd1 : 32'd0, 32'd1);
        do_conv("d65535", 6, 5, 5, 3, 5, 1'b0);
        do_conv("d65536", 6, 5, 5, 3, 6, 1'b0);
        do_conv("d99999", 9, 9, 9, 9, 9, 1'b0);

        // Idle with start low must not disturb held outputs.
        repeat (3) @(negedge clk);
        chk("idle_hold", {12'd0, busy, done, ovf, err, num}, {12'd0, 4'b0010, 16'hFFFF});

        do_conv("zero", 0, 0, 0, 0, 0, 1'b0);
        do_conv("bad_d0", 0, 0, 0, 1, 10, 1'b0);
        do_conv("held_start", 3, 1, 4, 1, 5, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("held_no_redo", {31'd0, done}, 32'd0);
        end

        // Abort during the third CONV cycle.
        D4 = 4'd1; D3 = 4'd2; D2 = 4'd3; D1 = 4'd4; D0 = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_clear", {12'd0, busy, done, ovf, err, num}, 32'd0);
        begin
            int pulses;
            pulses = 0;
            repeat (8) begin
                @(negedge clk);
                if (done) pulses++;
            end
            chk("abort_no_done", 32'(pulses), 32'd0);
        end
        do_conv("after_abort", 0, 0, 0, 4, 2, 1'b0);

        // Back-to-back: done pulses exactly 7 cycles apart, ovf cleared by second start.
        do_conv("b2b_first", 9, 9, 9, 9, 9, 1'b0);
        do_conv("b2b_second", 0, 0, 1, 2, 3, 1'b0);
        chk("b2b_spacing", 32'(last_done_t - prev_done_t), 32'd70);

        for (int n = 0; n < 20; n++) begin
            do_conv("random", $urandom_range(0, 11), $urandom_range(0, 11),
                    $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
